dpram_port_scheduler: RTL and testbench

DPRAM_PORT_SCHEDULER -- requirements
Module: dpram_port_scheduler

---
 rtl/dpram_port_scheduler_if.sv | 34 +++
 rtl/dpram_port_scheduler.sv | 171 +++++++++++++++++
 tb/tb_dpram_port_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_port_scheduler_if.sv
// Requester-side and memory-side signals of the dual-requester DPRAM port scheduler.
// The master modport is the requester/memory environment; the slave modport is the scheduler.
interface dpram_port_scheduler_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_DEPTH = 32
);
  localparam int AW = $clog2(ADDRESS_DEPTH);

  logic [1:0]              req;
  logic [1:0]              wr;
  logic [2*AW-1:0]         addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic                    hold;
  logic [1:0]              gnt;
  logic [1:0]              rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              wack;
  logic                    busy;
  logic                    mem_en;
  logic                    mem_wr;
  logic [AW-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output req, wr, addr, wdata, hold, mem_rdata,
    input  gnt, rvalid, rdata, wack, busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req, wr, addr, wdata, hold, mem_rdata,
    output gnt, rvalid, rdata, wack, busy, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dpram_port_scheduler.sv
// Round-robin scheduler sharing one pipelined memory port between two requesters.
// In-flight commands are tracked by tag shift registers sized to the fixed read/write
// latencies; those tags drive the rvalid/wack pulses and the same-address hazard checks.
module dpram_port_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_DEPTH = 32,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input logic                   clk,
  input logic                   rst,
  dpram_port_scheduler_if.slave bus
);
  localparam int AW = $clog2(ADDRESS_DEPTH);
  // A read tag lives until its rvalid cycle: one stage per memory cycle, plus the
  // mem_en stage and the rdata capture stage. A write tag lives until its wack cycle.
  localparam int RD_STAGES = READ_LATENCY + 2;
  localparam int WR_STAGES = WRITE_LATENCY + 1;

  typedef enum logic {PTR_REQ0 = 1'b0, PTR_REQ1 = 1'b1} ptr_t;

  ptr_t                  ptr;
  logic [AW-1:0]         req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  logic [RD_STAGES-1:0]  rd_v;
  logic                  rd_req  [RD_STAGES];
  logic [AW-1:0]         rd_addr [RD_STAGES];
  logic [WR_STAGES-1:0]  wr_v;
  logic                  wr_req  [WR_STAGES];
  logic [AW-1:0]         wr_addr [WR_STAGES];

  logic [1:0]            raw_block;
  logic [1:0]            war_block;
  logic [1:0]            eligible;
  logic [1:0]            gnt_c;
  logic                  acc_any;
  logic                  acc_idx;
  logic                  acc_wr;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  busy_n;

  logic                  mem_en_q;
  logic                  mem_wr_q;
  logic [AW-1:0]         mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  busy_q;

  // Split the packed per-requester address and write-data buses into per-requester words.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = bus.addr[i*AW +: AW];
      req_wdata[i] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A read waits behind any in-flight write to its address, a write behind any in-flight read.
  always_comb begin
    raw_block = '0;
    war_block = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < WR_STAGES; k++) begin
        if (wr_v[k] && (wr_addr[k] == req_addr[i])) begin
          raw_block[i] = 1'b1;
        end
      end
      for (int k = 0; k < RD_STAGES; k++) begin
        if (rd_v[k] && (rd_addr[k] == req_addr[i])) begin
          war_block[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      eligible[i] = bus.req[i] && !(bus.wr[i] ? war_block[i] : raw_block[i]);
    end
  end

  // Round-robin grant: the pointer only breaks ties, a lone eligible requester always wins.
  always_comb begin
    gnt_c = 2'b00;
    if (!rst && !bus.hold) begin
      if (eligible == 2'b11) begin
        gnt_c = (ptr == PTR_REQ1) ? 2'b10 : 2'b01;
      end else begin
        gnt_c = eligible;
      end
    end
  end

  assign acc_any   = |gnt_c;
  assign acc_idx   = gnt_c[1];
  assign acc_wr    = bus.wr[acc_idx];
  assign acc_addr  = req_addr[acc_idx];
  assign acc_wdata = req_wdata[acc_idx];

  // Busy tracks whether any tag will still be live next cycle, including a fresh accept.
  assign busy_n = acc_any | (|rd_v[RD_STAGES-2:0]) | (|wr_v[WR_STAGES-2:0]);

  // Memory-port strobe, captured command fields, fairness pointer and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr         <= PTR_REQ0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q <= acc_any;
      busy_q   <= busy_n;
      if (acc_any) begin
        mem_wr_q    <= acc_wr;
        mem_addr_q  <= acc_addr;
        mem_wdata_q <= acc_wdata;
        ptr         <= acc_idx ? PTR_REQ0 : PTR_REQ1;
      end
    end
  end

  // Completion tag pipelines; one stage per cycle so back-to-back accepts never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v <= '0;
      wr_v <= '0;
      for (int k = 0; k < RD_STAGES; k++) begin
        rd_req[k]  <= 1'b0;
        rd_addr[k] <= '0;
      end
      for (int k = 0; k < WR_STAGES; k++) begin
        wr_req[k]  <= 1'b0;
        wr_addr[k] <= '0;
      end
    end else begin
      rd_v       <= {rd_v[RD_STAGES-2:0], acc_any & ~acc_wr};
      wr_v       <= {wr_v[WR_STAGES-2:0], acc_any & acc_wr};
      rd_req[0]  <= acc_idx;
      rd_addr[0] <= acc_addr;
      wr_req[0]  <= acc_idx;
      wr_addr[0] <= acc_addr;
      for (int k = 1; k < RD_STAGES; k++) begin
        rd_req[k]  <= rd_req[k-1];
        rd_addr[k] <= rd_addr[k-1];
      end
      for (int k = 1; k < WR_STAGES; k++) begin
        wr_req[k]  <= wr_req[k-1];
        wr_addr[k] <= wr_addr[k-1];
      end
    end
  end

  // Capture memory read data in the cycle it is valid, one cycle ahead of the rvalid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_v[RD_STAGES-2]) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rvalid    = (rd_v[RD_STAGES-1] && !rst) ? (rd_req[RD_STAGES-1] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.wack      = (wr_v[WR_STAGES-1] && !rst) ? (wr_req[WR_STAGES-1] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata     = rst ? '0 : rdata_q;
  assign bus.busy      = busy_q & ~rst;
  assign bus.mem_en    = mem_en_q & ~rst;
  assign bus.mem_wr    = mem_wr_q & ~rst;
  assign bus.mem_addr  = rst ? '0 : mem_addr_q;
  assign bus.mem_wdata = rst ? '0 : mem_wdata_q;
endmodule

// File: tb/tb_dpram_port_scheduler.sv
// Directed bench for dpram_port_scheduler: a cycle-by-cycle vector table followed by
// hand-written sequences for hazards, hold, same-cycle completion and mid-flight reset.
module tb_dpram_port_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dpram_port_scheduler_if bus_if ();

  dpram_port_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic       rst;
    logic       hold;
    logic [1:0] req;
    logic [1:0] wr;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [7:0] mrd;
    logic [1:0] e_gnt;
    logic       e_men;
    logic       e_mwr;
    logic [4:0] e_maddr;
    logic [7:0] e_mwd;
    logic [1:0] e_rv;
    logic [1:0] e_wack;
    logic       e_busy;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic r, input logic h, input logic [1:0] rq, input logic [1:0] w,
    input logic [4:0] a0, input logic [4:0] a1, input logic [7:0] wd0, input logic [7:0] wd1,
    input logic [7:0] mrd, input logic [1:0] g, input logic men, input logic mwr,
    input logic [4:0] maddr, input logic [7:0] mwd, input logic [1:0] rv, input logic [1:0] wk,
    input logic bsy, input logic [7:0] rd);
    vec_t v;
    v.rst = r; v.hold = h; v.req = rq; v.wr = w; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.mrd = mrd; v.e_gnt = g; v.e_men = men; v.e_mwr = mwr;
    v.e_maddr = maddr; v.e_mwd = mwd; v.e_rv = rv; v.e_wack = wk; v.e_busy = bsy; v.e_rdata = rd;
    return v;
  endfunction

  task automatic applyStimulus(
    input logic r, input logic h, input logic [1:0] rq, input logic [1:0] w,
    input logic [4:0] a0, input logic [4:0] a1, input logic [7:0] wd0, input logic [7:0] wd1,
    input logic [7:0] mrd);
    @(posedge clk);
    #1;
    rst              = r;
    bus_if.hold      = h;
    bus_if.req       = rq;
    bus_if.wr        = w;
    bus_if.addr      = {a1, a0};
    bus_if.wdata     = {wd1, wd0};
    bus_if.mem_rdata = mrd;
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic idleCycle(input logic [7:0] mrd);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, mrd);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d_gnt", idx), 32'(bus_if.gnt), 32'(v.e_gnt));
    checkOutput($sformatf("v%0d_mem_en", idx), 32'(bus_if.mem_en), 32'(v.e_men));
    checkOutput($sformatf("v%0d_mem_wr", idx), 32'(bus_if.mem_wr), 32'(v.e_mwr));
    checkOutput($sformatf("v%0d_mem_addr", idx), 32'(bus_if.mem_addr), 32'(v.e_maddr));
    checkOutput($sformatf("v%0d_rvalid", idx), 32'(bus_if.rvalid), 32'(v.e_rv));
    checkOutput($sformatf("v%0d_wack", idx), 32'(bus_if.wack), 32'(v.e_wack));
    checkOutput($sformatf("v%0d_busy", idx), 32'(bus_if.busy), 32'(v.e_busy));
    if ((v.e_men && v.e_mwr) || v.rst) begin
      checkOutput($sformatf("v%0d_mem_wdata", idx), 32'(bus_if.mem_wdata), 32'(v.e_mwd));
    end
    if ((v.e_rv != 2'b00) || v.rst) begin
      checkOutput($sformatf("v%0d_rdata", idx), 32'(bus_if.rdata), 32'(v.e_rdata));
    end
  endtask

  initial begin
    bit got;
    int granted_at;

    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus_if.hold      = 1'b0;
    bus_if.req       = 2'b00;
    bus_if.wr        = 2'b00;
    bus_if.addr      = '0;
    bus_if.wdata     = '0;
    bus_if.mem_rdata = '0;

    // Reset, single read of addr 5 with memory data 0xA5 four cycles after mem_en.
    vecs.push_back(mk(1'b1,1'b0,2'b11,2'b00,5'd0,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd0,8'h00,2'b00,2'b00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,1'b0,2'b11,2'b00,5'd0,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd0,8'h00,2'b00,2'b00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b01,2'b00,5'd5,5'd0,8'h00,8'h00,8'h00, 2'b01,1'b0,1'b0,5'd0,8'h00,2'b00,2'b00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b1,1'b0,5'd5,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd5,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd5,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'h11, 2'b00,1'b0,1'b0,5'd5,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'hA5, 2'b00,1'b0,1'b0,5'd5,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'h22, 2'b00,1'b0,1'b0,5'd5,8'h00,2'b01,2'b00,1'b1,8'hA5));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd5,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd5,8'h00,2'b00,2'b00,1'b0,8'h00));
    // Reset, then both requesters reading continuously: grants must alternate.
    vecs.push_back(mk(1'b1,1'b0,2'b00,2'b00,5'd0,5'd0,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd0,8'h00,2'b00,2'b00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b11,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b01,1'b0,1'b0,5'd0,8'h00,2'b00,2'b00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b11,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b10,1'b1,1'b0,5'd1,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b11,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b01,1'b1,1'b0,5'd2,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b11,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b10,1'b1,1'b0,5'd1,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b00,1'b1,1'b0,5'd2,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h31, 2'b00,1'b0,1'b0,5'd2,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h32, 2'b00,1'b0,1'b0,5'd2,8'h00,2'b01,2'b00,1'b1,8'h31));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h33, 2'b00,1'b0,1'b0,5'd2,8'h00,2'b10,2'b00,1'b1,8'h32));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h34, 2'b00,1'b0,1'b0,5'd2,8'h00,2'b01,2'b00,1'b1,8'h33));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd2,8'h00,2'b10,2'b00,1'b1,8'h34));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd1,5'd2,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b0,5'd2,8'h00,2'b00,2'b00,1'b0,8'h00));
    // Lone write from requester 1 is granted even though the pointer favours requester 0.
    vecs.push_back(mk(1'b0,1'b0,2'b10,2'b10,5'd0,5'd9,8'h00,8'h5C,8'h00, 2'b10,1'b0,1'b0,5'd2,8'h00,2'b00,2'b00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd0,5'd9,8'h00,8'h00,8'h00, 2'b00,1'b1,1'b1,5'd9,8'h5C,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd0,5'd9,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b1,5'd9,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd0,5'd9,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b1,5'd9,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd0,5'd9,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b1,5'd9,8'h00,2'b00,2'b00,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd0,5'd9,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b1,5'd9,8'h00,2'b00,2'b10,1'b1,8'h00));
    vecs.push_back(mk(1'b0,1'b0,2'b00,2'b00,5'd0,5'd9,8'h00,8'h00,8'h00, 2'b00,1'b0,1'b1,5'd9,8'h00,2'b00,2'b00,1'b0,8'h00));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].hold, vecs[i].req, vecs[i].wr, vecs[i].a0, vecs[i].a1,
                    vecs[i].wd0, vecs[i].wd1, vecs[i].mrd);
      checkVector(i, vecs[i]);
    end

    // Read-after-write: requester 1 reads addr 7 while requester 0's write is in flight.
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b01, 5'd7, 5'd0, 8'h77, 8'h00, 8'h00);
    checkOutput("raw_wr_gnt", 32'(bus_if.gnt), 32'(2'b01));
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 2'b10, 2'b00, 5'd0, 5'd7, 8'h00, 8'h00, 8'h00);
      checkOutput($sformatf("raw_block_t%0d", k), 32'(bus_if.gnt), 32'(2'b00));
      checkOutput($sformatf("raw_wack_t%0d", k), 32'(bus_if.wack), 32'((k == 5) ? 2'b01 : 2'b00));
      if (k == 1) begin
        checkOutput("raw_mem_en", 32'(bus_if.mem_en), 32'(1'b1));
        checkOutput("raw_mem_wr", 32'(bus_if.mem_wr), 32'(1'b1));
        checkOutput("raw_mem_addr", 32'(bus_if.mem_addr), 32'(5'd7));
        checkOutput("raw_mem_wdata", 32'(bus_if.mem_wdata), 32'(8'h77));
      end
    end
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b00, 5'd0, 5'd7, 8'h00, 8'h00, 8'h00);
    checkOutput("raw_release_gnt", 32'(bus_if.gnt), 32'(2'b10));
    checkOutput("raw_release_wack", 32'(bus_if.wack), 32'(2'b00));
    idleCycle(8'h00);
    checkOutput("raw_rd_mem_en", 32'(bus_if.mem_en), 32'(1'b1));
    checkOutput("raw_rd_mem_wr", 32'(bus_if.mem_wr), 32'(1'b0));
    checkOutput("raw_rd_mem_addr", 32'(bus_if.mem_addr), 32'(5'd7));
    for (int k = 8; k <= 12; k++) begin
      idleCycle((k == 11) ? 8'h77 : 8'h00);
      checkOutput($sformatf("raw_rvalid_t%0d", k), 32'(bus_if.rvalid), 32'((k == 12) ? 2'b10 : 2'b00));
      if (k == 12) begin
        checkOutput("raw_rdata", 32'(bus_if.rdata), 32'(8'h77));
      end
    end

    // Write-after-read: a write to a different address passes, one to the read address waits.
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b00, 5'd3, 5'd0, 8'h00, 8'h00, 8'h00);
    checkOutput("war_rd_gnt", 32'(bus_if.gnt), 32'(2'b01));
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 5'd3, 5'd4, 8'h00, 8'h44, 8'h00);
    checkOutput("war_other_addr_gnt", 32'(bus_if.gnt), 32'(2'b10));
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 5'd3, 5'd3, 8'h00, 8'h33, 8'h00);
      checkOutput($sformatf("war_block_t%0d", k), 32'(bus_if.gnt), 32'(2'b00));
    end
    got        = 1'b0;
    granted_at = 0;
    for (int k = 6; k <= 9; k++) begin
      applyStimulus(1'b0, 1'b0, got ? 2'b00 : 2'b10, 2'b10, 5'd3, 5'd3, 8'h00, 8'h33, 8'h00);
      if (k == 6) begin
        checkOutput("war_rvalid", 32'(bus_if.rvalid), 32'(2'b01));
        checkOutput("war_wack_same_cycle", 32'(bus_if.wack), 32'(2'b10));
      end
      if (!got && (bus_if.gnt == 2'b10)) begin
        got        = 1'b1;
        granted_at = k;
      end
    end
    checkOutput($sformatf("war_release_at_t%0d", granted_at), 32'(got && (granted_at == 6 || granted_at == 7)), 32'(1'b1));

    // Hold for three cycles after two accepts; in-flight reads still complete.
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 5'd10, 5'd11, 8'h00, 8'h00, 8'h00);
    checkOutput("hold_gnt0", 32'(bus_if.gnt), 32'(2'b01));
    applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 5'd10, 5'd11, 8'h00, 8'h00, 8'h00);
    checkOutput("hold_gnt1", 32'(bus_if.gnt), 32'(2'b10));
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, 2'b00, 5'd10, 5'd11, 8'h00, 8'h00, 8'h00);
      checkOutput($sformatf("hold_gnt_t%0d", k), 32'(bus_if.gnt), 32'(2'b00));
      checkOutput($sformatf("hold_mem_en_t%0d", k), 32'(bus_if.mem_en), 32'(k == 2));
      checkOutput($sformatf("hold_busy_t%0d", k), 32'(bus_if.busy), 32'(1'b1));
    end
    for (int k = 5; k <= 8; k++) begin
      idleCycle(8'h00);
      checkOutput($sformatf("hold_rvalid_t%0d", k), 32'(bus_if.rvalid),
                  32'((k == 6) ? 2'b01 : ((k == 7) ? 2'b10 : 2'b00)));
      checkOutput($sformatf("hold_busy_t%0d", k), 32'(bus_if.busy), 32'(k <= 7));
    end

    // Read from requester 0 and write from requester 1 finishing in the same cycle.
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b00, 5'd20, 5'd0, 8'h00, 8'h00, 8'h00);
    checkOutput("same_rd_gnt", 32'(bus_if.gnt), 32'(2'b01));
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 5'd0, 5'd21, 8'h00, 8'h99, 8'h00);
    checkOutput("same_wr_gnt", 32'(bus_if.gnt), 32'(2'b10));
    for (int k = 2; k <= 6; k++) begin
      idleCycle(8'h00);
      if (k >= 5) begin
        checkOutput($sformatf("same_rvalid_t%0d", k), 32'(bus_if.rvalid), 32'((k == 6) ? 2'b01 : 2'b00));
        checkOutput($sformatf("same_wack_t%0d", k), 32'(bus_if.wack), 32'((k == 6) ? 2'b10 : 2'b00));
      end
    end

    // Reset while a read is in flight: outputs zero during reset, no late rvalid.
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b00, 5'd12, 5'd0, 8'h00, 8'h00, 8'h00);
    checkOutput("rstmid_gnt", 32'(bus_if.gnt), 32'(2'b01));
    idleCycle(8'h00);
    checkOutput("rstmid_mem_en", 32'(bus_if.mem_en), 32'(1'b1));
    checkOutput("rstmid_mem_addr", 32'(bus_if.mem_addr), 32'(5'd12));
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 5'd12, 5'd12, 8'h00, 8'h00, 8'h00);
    checkOutput("rstmid_in_gnt", 32'(bus_if.gnt), 32'(2'b00));
    checkOutput("rstmid_in_busy", 32'(bus_if.busy), 32'(1'b0));
    checkOutput("rstmid_in_mem_en", 32'(bus_if.mem_en), 32'(1'b0));
    checkOutput("rstmid_in_mem_wr", 32'(bus_if.mem_wr), 32'(1'b0));
    checkOutput("rstmid_in_mem_addr", 32'(bus_if.mem_addr), 32'(5'd0));
    checkOutput("rstmid_in_mem_wdata", 32'(bus_if.mem_wdata), 32'(8'h00));
    checkOutput("rstmid_in_rvalid", 32'(bus_if.rvalid), 32'(2'b00));
    checkOutput("rstmid_in_wack", 32'(bus_if.wack), 32'(2'b00));
    checkOutput("rstmid_in_rdata", 32'(bus_if.rdata), 32'(8'h00));
    for (int k = 3; k <= 8; k++) begin
      idleCycle(8'hEE);
      checkOutput($sformatf("rstmid_rvalid_t%0d", k), 32'(bus_if.rvalid), 32'(2'b00));
      checkOutput($sformatf("rstmid_busy_t%0d", k), 32'(bus_if.busy), 32'(1'b0));
      checkOutput($sformatf("rstmid_mem_en_t%0d", k), 32'(bus_if.mem_en), 32'(1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
